prf_wb_bank_arbiter: RTL and testbench

Arbitrates the PRF_WR_COUNT writeback requesters (functional-unit result buses) onto the PRF_BANK_COUNT single-write-port PRF banks. Each cycle it grants at most one requester per bank, round-robin per bank, and drives a registered bank write port plus a writeback-complete broadcast. It sits between the execution pipes and the banked PRF; requesters hold results until granted.

---
 rtl/core_types_pkg.sv | 15 +
 rtl/prf_bank_rr_arbiter.sv | 81 ++++++++
 rtl/prf_wb_bank_arbiter.sv | 122 ++++++++++++
 tb/tb_prf_wb_bank_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// -----------------------------------------------------------------------------
// core_types_pkg
// Core-wide sizing constants shared by the execution back end and the banked
// physical register file.
// -----------------------------------------------------------------------------
package core_types_pkg;

    localparam int PRF_WR_COUNT       = 7;    // writeback requesters (FU result buses)
    localparam int PRF_BANK_COUNT     = 4;    // single-write-port PRF banks
    localparam int LOG_PRF_BANK_COUNT = 2;
    localparam int PR_COUNT           = 128;  // physical registers
    localparam int LOG_PR_COUNT       = 7;
    localparam int XLEN               = 32;   // data width

endpackage : core_types_pkg

// File: rtl/prf_bank_rr_arbiter.sv
// -----------------------------------------------------------------------------
// prf_bank_rr_arbiter
// Round-robin arbiter for one PRF bank write port. Picks the lowest requesting
// index at or above the pointer, otherwise wraps to the lowest requester. The
// pointer moves to winner+1 only when something is granted.
//
// Ports:
//   CLK           in   clock, rising edge
//   nRST          in   asynchronous active-low reset (pointer -> 0)
//   req_vec       in   requesters targeting this bank
//   grant_onehot  out  one-hot grant (all zero when req_vec is zero)
// -----------------------------------------------------------------------------
module prf_bank_rr_arbiter
    import core_types_pkg::*;
(
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [PRF_WR_COUNT-1:0] req_vec,
    output logic [PRF_WR_COUNT-1:0] grant_onehot
);

    localparam int               PTR_W    = $clog2(PRF_WR_COUNT);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PRF_WR_COUNT - 1);

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;
    logic [PTR_W-1:0] winner_idx;
    logic             found_upper;
    logic             found_any;
    logic             granted;

    // NOTE: every variable gets a default at the top of a combinational block,
    // so no path through the loops and ifs can leave it unassigned (no latch).
    always_comb begin
        winner_idx  = '0;
        found_upper = 1'b0;
        found_any   = 1'b0;
        granted     = |req_vec;

        // First pass: lowest requester at or above the pointer.
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            if (req_vec[i] && !found_upper && (PTR_W'(i) >= rr_ptr_q)) begin
                found_upper = 1'b1;
                winner_idx  = PTR_W'(i);
            end
        end

        // Second pass only matters when nothing sits at/above the pointer: wrap.
        if (!found_upper) begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (req_vec[i] && !found_any) begin
                    found_any  = 1'b1;
                    winner_idx = PTR_W'(i);
                end
            end
        end

        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            grant_onehot[i] = granted && (winner_idx == PTR_W'(i));
        end

        if (!granted) begin
            rr_ptr_d = rr_ptr_q;
        end else if (winner_idx == LAST_IDX) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = winner_idx + 1'b1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule : prf_bank_rr_arbiter

// File: rtl/prf_wb_bank_arbiter.sv
// -----------------------------------------------------------------------------
// prf_wb_bank_arbiter
// Arbitrates the writeback requesters onto the banked PRF. Bank = PR[1:0],
// row = PR[6:2]. One round-robin arbiter per bank grants at most one requester
// per bank per cycle; the granted PR/data are registered into the bank write
// port and mirrored as a writeback-complete broadcast one cycle later.
//
// Ports:
//   CLK, nRST               clock / asynchronous active-low reset
//   req_valid_by_wr         requester i holds a result
//   req_PR_by_wr            destination physical register per requester
//   req_data_by_wr          result data per requester
//   req_ready_by_wr         requester i granted this cycle (combinational)
//   WEN_by_bank             registered bank write enable
//   waddr_by_bank           registered row within bank
//   wdata_by_bank           registered write data
//   complete_valid_by_bank  registered, identical to WEN_by_bank
//   complete_PR_by_bank     registered full PR written (wakeup / ROB complete)
// -----------------------------------------------------------------------------
module prf_wb_bank_arbiter
    import core_types_pkg::*;
(
    input  logic                                                        CLK,
    input  logic                                                        nRST,
    input  logic [PRF_WR_COUNT-1:0]                                     req_valid_by_wr,
    input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]                   req_PR_by_wr,
    input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]                           req_data_by_wr,
    output logic [PRF_WR_COUNT-1:0]                                     req_ready_by_wr,
    output logic [PRF_BANK_COUNT-1:0]                                   WEN_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] waddr_by_bank,
    output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]                         wdata_by_bank,
    output logic [PRF_BANK_COUNT-1:0]                                   complete_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]                 complete_PR_by_bank
);

    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] req_by_bank;
    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] grant_by_bank;
    logic [PRF_BANK_COUNT-1:0]                   bank_granted;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] sel_pr;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]         sel_data;

    logic [PRF_BANK_COUNT-1:0]                   wen_q;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]         wdata_q;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] complete_pr_q;

    // Bank decode: requester i competes only in the bank its PR maps to.
    always_comb begin
        req_by_bank = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                req_by_bank[b][i] = req_valid_by_wr[i] &&
                    (req_PR_by_wr[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
            end
        end
    end

    for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
        prf_bank_rr_arbiter u_rr (
            .CLK          (CLK),
            .nRST         (nRST),
            .req_vec      (req_by_bank[b]),
            .grant_onehot (grant_by_bank[b])
        );
    end

    // A requester maps to exactly one bank, so OR-ing grants across banks
    // never merges two grants for the same requester.
    always_comb begin
        req_ready_by_wr = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            req_ready_by_wr = req_ready_by_wr | grant_by_bank[b];
        end
    end

    // One-hot AND-OR mux of PR/data per bank.
    always_comb begin
        sel_pr       = '0;
        sel_data     = '0;
        bank_granted = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            bank_granted[b] = |grant_by_bank[b];
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (grant_by_bank[b][i]) begin
                    sel_pr[b]   = sel_pr[b]   | req_PR_by_wr[i];
                    sel_data[b] = sel_data[b] | req_data_by_wr[i];
                end
            end
        end
    end

    // NOTE: the payload registers are reset as well as the enable so the write
    // port reads all-zero out of reset, and each bank's payload only loads on
    // its own grant, holding otherwise.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wen_q         <= '0;
            wdata_q       <= '0;
            complete_pr_q <= '0;
        end else begin
            wen_q <= bank_granted;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (bank_granted[b]) begin
                    wdata_q[b]       <= sel_data[b];
                    complete_pr_q[b] <= sel_pr[b];
                end
            end
        end
    end

    // Row is a fixed slice of the registered PR, so it needs no flop of its own.
    always_comb begin
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            waddr_by_bank[b] = complete_pr_q[b][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
        end
    end

    assign WEN_by_bank            = wen_q;
    assign complete_valid_by_bank = wen_q;
    assign wdata_by_bank          = wdata_q;
    assign complete_PR_by_bank    = complete_pr_q;

endmodule : prf_wb_bank_arbiter

// File: tb/tb_prf_wb_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prf_wb_bank_arbiter
// Directed vectors with hand-computed expectations, followed by a random run
// checked against an independent round-robin reference and a scoreboard of
// the registered write port.
// -----------------------------------------------------------------------------
module tb_prf_wb_bank_arbiter;
    import core_types_pkg::*;

    localparam int ROW_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    logic                                             clk;
    logic                                             rst_n;
    logic [PRF_WR_COUNT-1:0]                          req_valid;
    logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]        req_pr;
    logic [PRF_WR_COUNT-1:0][XLEN-1:0]                req_data;
    logic [PRF_WR_COUNT-1:0]                          req_ready;
    logic [PRF_BANK_COUNT-1:0]                        wen;
    logic [PRF_BANK_COUNT-1:0][ROW_W-1:0]             waddr;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]              wdata;
    logic [PRF_BANK_COUNT-1:0]                        cvalid;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]      cpr;

    int n_tests = 0;
    int n_fail  = 0;
    bit hold_chk_en = 1'b0;

    prf_wb_bank_arbiter dut (
        .CLK                    (clk),
        .nRST                   (rst_n),
        .req_valid_by_wr        (req_valid),
        .req_PR_by_wr           (req_pr),
        .req_data_by_wr         (req_data),
        .req_ready_by_wr        (req_ready),
        .WEN_by_bank            (wen),
        .waddr_by_bank          (waddr),
        .wdata_by_bank          (wdata),
        .complete_valid_by_bank (cvalid),
        .complete_PR_by_bank    (cpr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requester hold rule: a pending, ungranted request must not change.
    logic [PRF_WR_COUNT-1:0]                   hv_q, hr_q;
    logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0] hp_q;
    logic [PRF_WR_COUNT-1:0][XLEN-1:0]         hd_q;
    initial begin hv_q = '0; hr_q = '0; hp_q = '0; hd_q = '0; end
    always @(negedge clk) begin
        if (hold_chk_en) begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (hv_q[i] && !hr_q[i]) begin
                    assert (req_valid[i] && req_pr[i] == hp_q[i] && req_data[i] == hd_q[i])
                    else $error("FAIL hold_rule: requester %0d changed before ready", i);
                end
            end
        end
        hv_q = req_valid;
        hr_q = req_ready;
        hp_q = req_pr;
        hd_q = req_data;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Leaves the bench at posedge+1 with all requests idle and pointers at 0.
    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random run.
    int                        ptr_m  [PRF_BANK_COUNT];
    int                        win_m  [PRF_BANK_COUNT];
    int                        wait_cnt[PRF_WR_COUNT];
    logic [PRF_BANK_COUNT-1:0] exp_wen;
    logic [LOG_PR_COUNT-1:0]   exp_pr  [PRF_BANK_COUNT];
    logic [XLEN-1:0]           exp_data[PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0]   exp_ready;
    logic [PRF_WR_COUNT-1:0]   rdy_s;

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_pr    = '0;
        req_data  = '0;

        // ---- Reset with every requester valid, PR[i] = i --------------------
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            req_valid[i] = 1'b1;
            req_pr[i]    = LOG_PR_COUNT'(i);
            req_data[i]  = 32'hD000_0000 | XLEN'(i);
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_wen",    64'(wen),    64'h0);
        check("rst_cvalid", 64'(cvalid), 64'h0);
        check("rst_waddr",  64'(waddr),  64'h0);
        check("rst_cpr",    64'(cpr),    64'h0);
        check("rst_wdata",  64'(|wdata), 64'h0);
        // Pointers at 0: lowest requester per bank -> 0,1,2,3.
        check("rst_ready",  64'(req_ready), 64'h0F);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        req_valid = '0;
        #1;
        check("rel_wen", 64'(wen), 64'hF);
        check("rel_cpr", 64'(cpr), {36'h0, 7'd3, 7'd2, 7'd1, 7'd0});
        check("rel_wdata0", 64'(wdata[0]), 64'hD000_0000);
        check("rel_wdata3", 64'(wdata[3]), 64'hD000_0003);

        // ---- Independent banks: PR 4,5,6,7 on requesters 0..3 ---------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b1;
            req_pr[i]    = LOG_PR_COUNT'(4 + i);
            req_data[i]  = 32'hA5A5_0000 + XLEN'(i);
        end
        #1;
        check("ind_ready", 64'(req_ready), 64'h0F);
        step();
        req_valid = '0;
        #1;
        check("ind_wen",    64'(wen),    64'hF);
        check("ind_cvalid", 64'(cvalid), 64'hF);
        check("ind_waddr",  64'(waddr),  {44'h0, 5'd1, 5'd1, 5'd1, 5'd1});
        check("ind_cpr",    64'(cpr),    {36'h0, 7'd7, 7'd6, 7'd5, 7'd4});
        check("ind_wdata2", 64'(wdata[2]), 64'hA5A5_0002);
        step();
        check("idle_wen",   64'(wen),       64'h0);
        check("idle_ready", 64'(req_ready), 64'h0);

        // ---- Same-bank contention: req 0,3,6 -> PR 8,12,16 (bank 0) ----------
        do_reset();
        req_valid[0] = 1'b1; req_pr[0] = 7'd8;  req_data[0] = 32'h1111_0008;
        req_valid[3] = 1'b1; req_pr[3] = 7'd12; req_data[3] = 32'h3333_000C;
        req_valid[6] = 1'b1; req_pr[6] = 7'd16; req_data[6] = 32'h6666_0010;
        #1;
        check("sb_ready0", 64'(req_ready), 64'h01);
        step();
        req_valid[0] = 1'b0;
        #1;
        check("sb_wen0",   64'(wen),      64'h1);
        check("sb_waddr0", 64'(waddr[0]), 64'd2);
        check("sb_data0",  64'(wdata[0]), 64'h1111_0008);
        check("sb_ready1", 64'(req_ready), 64'h08);
        step();
        req_valid[3] = 1'b0;
        #1;
        check("sb_wen1",   64'(wen),      64'h1);
        check("sb_waddr1", 64'(waddr[0]), 64'd3);
        check("sb_ready2", 64'(req_ready), 64'h40);
        step();
        req_valid[6] = 1'b0;
        #1;
        check("sb_wen2",   64'(wen),      64'h1);
        check("sb_waddr2", 64'(waddr[0]), 64'd4);
        check("sb_cpr2",   64'(cpr[0]),   64'd16);
        check("sb_ready3", 64'(req_ready), 64'h00);
        step();
        check("sb_wen3", 64'(wen), 64'h0);

        // ---- Wrap-around in bank 1 ------------------------------------------
        do_reset();
        req_valid[5] = 1'b1; req_pr[5] = 7'd1; req_data[5] = 32'h5555_0001;
        #1;
        check("wr_ready5", 64'(req_ready), 64'h20);
        step();
        req_valid[5] = 1'b0;
        req_valid[1] = 1'b1; req_pr[1] = 7'd5; req_data[1] = 32'h1111_0005;
        req_valid[6] = 1'b1; req_pr[6] = 7'd9; req_data[6] = 32'h6666_0009;
        #1;
        check("wr_ready6", 64'(req_ready), 64'h40);   // pointer 6
        check("wr_cpr5",   64'(cpr[1]),    64'd1);
        step();
        req_valid[6] = 1'b0;
        #1;
        check("wr_ready1", 64'(req_ready), 64'h02);   // pointer wrapped to 0
        check("wr_cpr6",   64'(cpr[1]),    64'd9);
        check("wr_waddr6", 64'(waddr[1]),  64'd2);
        step();
        req_valid[1] = 1'b0;
        req_valid[0] = 1'b1; req_pr[0] = 7'd13; req_data[0] = 32'h0000_000D;
        req_valid[2] = 1'b1; req_pr[2] = 7'd17; req_data[2] = 32'h2222_0011;
        #1;
        check("wr_ptr2",   64'(req_ready), 64'h04);   // pointer 2 skips req 0
        check("wr_cpr1",   64'(cpr[1]),    64'd5);
        check("wr_data1",  64'(wdata[1]),  64'h1111_0005);
        step();
        req_valid = '0;

        // ---- Mid-operation reset --------------------------------------------
        do_reset();
        req_valid[2] = 1'b1; req_pr[2] = 7'd9;  req_data[2] = 32'h2222_0009;
        req_valid[5] = 1'b1; req_pr[5] = 7'd13; req_data[5] = 32'h5555_000D;
        #1;
        check("mr_ready_a", 64'(req_ready), 64'h04);
        step();
        #1;
        check("mr_wen_a",   64'(wen),       64'h2);
        check("mr_cpr_a",   64'(cpr[1]),    64'd9);
        check("mr_ready_b", 64'(req_ready), 64'h20);  // pointer moved to 3
        rst_n = 1'b0;
        #1;
        check("mr_wen_async", 64'(wen),       64'h0);
        check("mr_cv_async",  64'(cvalid),    64'h0);
        check("mr_ready_rst", 64'(req_ready), 64'h04); // pointer back at 0
        #2;
        rst_n = 1'b1;
        #1;
        check("mr_ready_rel", 64'(req_ready), 64'h04);
        step();
        #1;
        check("mr_wen_b", 64'(wen),    64'h2);
        check("mr_cpr_b", 64'(cpr[1]), 64'd9);
        req_valid = '0;

        // ---- Random run against the reference model -------------------------
        do_reset();
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            ptr_m[b]    = 0;
            exp_pr[b]   = '0;
            exp_data[b] = '0;
        end
        for (int i = 0; i < PRF_WR_COUNT; i++) wait_cnt[i] = 0;
        exp_wen     = '0;
        hold_chk_en = 1'b1;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_valid[i] = 1'b1;
                    req_pr[i]    = LOG_PR_COUNT'($urandom_range(PR_COUNT - 1, 0));
                    req_data[i]  = $urandom;
                end
            end
            #1;
            exp_ready = '0;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                win_m[b] = -1;
                for (int k = 0; k < PRF_WR_COUNT; k++) begin
                    int idx;
                    idx = (ptr_m[b] + k) % PRF_WR_COUNT;
                    if (win_m[b] < 0 && req_valid[idx] &&
                        req_pr[idx][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b))
                        win_m[b] = idx;
                end
                if (win_m[b] >= 0) exp_ready[win_m[b]] = 1'b1;
            end
            check("rnd_ready",  64'(req_ready), 64'(exp_ready));
            check("rnd_wen",    64'(wen),       64'(exp_wen));
            check("rnd_cvalid", 64'(cvalid),    64'(exp_wen));
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (exp_wen[b]) begin
                    check("rnd_cpr",   64'(cpr[b]),   64'(exp_pr[b]));
                    check("rnd_waddr", 64'(waddr[b]), 64'(exp_pr[b][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]));
                    check("rnd_wdata", 64'(wdata[b]), 64'(exp_data[b]));
                end
            end
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                exp_wen[b] = (win_m[b] >= 0);
                if (win_m[b] >= 0) begin
                    exp_pr[b]   = req_pr[win_m[b]];
                    exp_data[b] = req_data[win_m[b]];
                    ptr_m[b]    = (win_m[b] + 1) % PRF_WR_COUNT;
                    check("rnd_starve", 64'(wait_cnt[win_m[b]] <= PRF_WR_COUNT - 1), 64'h1);
                    wait_cnt[win_m[b]] = 0;
                    for (int i = 0; i < PRF_WR_COUNT; i++) begin
                        if (i != win_m[b] && req_valid[i] &&
                            req_pr[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b))
                            wait_cnt[i]++;
                    end
                end
            end
            rdy_s = req_ready;
            step();
            req_valid = req_valid & ~rdy_s;
        end
        hold_chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_prf_wb_bank_arbiter
